// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation scheduler and mode controllers.
package ascon_pkg;

   localparam int unsigned ROUND_W          = 4;
   localparam int unsigned ASCON_ROUNDS_MAX = 12;

   localparam logic PORT_AEAD = 1'b0;
   localparam logic PORT_HASH = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_HOLD = 3'd4
   } sched_state_e;

   // Parameters of one accepted permutation call.
   typedef struct packed {
      logic [ROUND_W-1:0] rounds;
      logic               load;
      logic               lock;
   } perm_call_t;

   // Zero stays zero (no rounds); anything above the core maximum saturates.
   function automatic logic [ROUND_W-1:0] clamp_rounds(
      input logic [ROUND_W-1:0] rounds,
      input logic [ROUND_W-1:0] max_rounds
   );
      return (rounds > max_rounds) ? max_rounds : rounds;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer picks the winner on a tie.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt_c
);

   always_comb begin
      gnt_c = req;
      if (req == 2'b11) begin
         gnt_c = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/ascon_perm_sched.sv
// Shares one asconp core between the AEAD and hash engines: arbitration,
// optional ownership lock, and per-call load/round sequencing.
module ascon_perm_sched
   import ascon_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = ASCON_ROUNDS_MAX
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_i,
   input  logic [ROUND_W-1:0] rounds0_i,
   input  logic [ROUND_W-1:0] rounds1_i,
   input  logic [1:0]         load_i,
   input  logic [1:0]         lock_i,
   input  logic [1:0]         release_i,
   output logic [1:0]         gnt_o,
   output logic [1:0]         done_o,
   output logic               owner_o,
   output logic               busy_o,
   output logic               load_init_val_o,
   output logic               rounds_enable_o,
   output logic [ROUND_W-1:0] round_ctr_o
);

   localparam logic [ROUND_W-1:0] NR = ROUND_W'(NUM_ROUNDS);

   sched_state_e       state_q, state_n;
   perm_call_t         call_q, call_n;
   logic               owner_q, owner_n;
   logic               rr_ptr_q, rr_ptr_n;
   logic [ROUND_W-1:0] ctr_q, ctr_n;
   logic [1:0]         done_q, done_n;
   logic               busy_q, load_q, ren_q;

   logic [1:0]         arb_gnt;
   logic               accept;
   logic               win;
   logic [ROUND_W-1:0] win_rounds;

   rr_arb2 u_arb (
      .req   (req_i),
      .ptr   (rr_ptr_q),
      .gnt_c (arb_gnt)
   );

   // Next-state, accept and round-index logic.
   always_comb begin
      state_n    = state_q;
      call_n     = call_q;
      owner_n    = owner_q;
      rr_ptr_n   = rr_ptr_q;
      ctr_n      = '0;
      done_n     = '0;
      gnt_o      = '0;
      accept     = 1'b0;
      win        = PORT_AEAD;
      win_rounds = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (|arb_gnt) begin
               accept = 1'b1;
               gnt_o  = arb_gnt;
               win    = arb_gnt[1] ? PORT_HASH : PORT_AEAD;
            end
         end
         ST_LOAD: state_n = (call_q.rounds != '0) ? ST_RUN : ST_DONE;
         ST_RUN: begin
            if (ctr_q == NR - ROUND_W'(1)) state_n = ST_DONE;
         end
         ST_DONE: begin
            if (call_q.lock) begin
               state_n = ST_HOLD;
            end else begin
               state_n  = ST_IDLE;
               rr_ptr_n = ~owner_q;
            end
         end
         ST_HOLD: begin
            // Owner request beats a simultaneous owner release.
            if (req_i[owner_q]) begin
               accept         = 1'b1;
               gnt_o[owner_q] = 1'b1;
               win            = owner_q;
            end else if (release_i[owner_q]) begin
               state_n  = ST_IDLE;
               rr_ptr_n = ~rr_ptr_q;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (accept) begin
         win_rounds    = (win == PORT_HASH) ? rounds1_i : rounds0_i;
         call_n.rounds = clamp_rounds(win_rounds, NR);
         call_n.load   = load_i[win];
         call_n.lock   = lock_i[win];
         owner_n       = win;
         if (call_n.load)               state_n = ST_LOAD;
         else if (call_n.rounds != '0)  state_n = ST_RUN;
         else                           state_n = ST_DONE;
      end

      if (state_n == ST_RUN) begin
         ctr_n = (state_q == ST_RUN) ? ctr_q + ROUND_W'(1) : NR - call_n.rounds;
      end

      if (state_n == ST_DONE) begin
         done_n = (owner_n == PORT_HASH) ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         call_q   <= '0;
         owner_q  <= PORT_AEAD;
         rr_ptr_q <= 1'b0;
         ctr_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         load_q   <= 1'b0;
         ren_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         call_q   <= call_n;
         owner_q  <= owner_n;
         rr_ptr_q <= rr_ptr_n;
         ctr_q    <= ctr_n;
         done_q   <= done_n;
         busy_q   <= (state_n != ST_IDLE);
         load_q   <= (state_n == ST_LOAD);
         ren_q    <= (state_n == ST_RUN);
      end
   end

   assign done_o          = done_q;
   assign owner_o         = owner_q;
   assign busy_o          = busy_q;
   assign load_init_val_o = load_q;
   assign rounds_enable_o = ren_q;
   assign round_ctr_o     = ctr_q;

endmodule
